// File: rtl/key_command_decoder.sv
// Turns UART key bytes into the Player instruction word: held movement bits plus queued one-tick action pulses.
// Build option KEY_ARROW_EN adds a VT100 escape-sequence decoder (ESC [ A..D) for arrow keys.
module key_command_decoder #(
    parameter int unsigned HOLD_TICKS        = 3,
    parameter int unsigned FIFO_DEPTH        = 4,
    parameter int unsigned ESC_TIMEOUT_TICKS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        tick,
    output logic [15:0] instruction,
    output logic        any_key,
    output logic        overflow,
    output logic [7:0]  unknown_count
);

    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam logic [3:0]  HOLD_LOAD = 4'(HOLD_TICKS);

    if (HOLD_TICKS < 1 || HOLD_TICKS > 15 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || ESC_TIMEOUT_TICKS < 1) begin : g_param_check
        $error("key_command_decoder: illegal parameter value");
    end

    // Case-insensitive decode of a plain key byte
    logic [7:0] lc_byte;
    logic [3:0] plain_mv;
    logic [2:0] plain_act;

    always_comb begin
        lc_byte   = rx_byte;
        plain_mv  = '0;
        plain_act = '0;
        if (rx_byte >= 8'h41 && rx_byte <= 8'h5A) begin
            lc_byte = rx_byte | 8'h20;
        end
        case (lc_byte)
            8'h77:        plain_mv  = 4'b0001;
            8'h73:        plain_mv  = 4'b0010;
            8'h61:        plain_mv  = 4'b0100;
            8'h64:        plain_mv  = 4'b1000;
            8'h20, 8'h7A: plain_act = 3'b001;
            8'h0D:        plain_act = 3'b010;
            8'h78:        plain_act = 3'b100;
            default:      ;
        endcase
    end

    logic       decode_en;
    logic [3:0] arrow_mv;
    logic       esc_unknown;

`ifdef KEY_ARROW_EN
    localparam int unsigned ESC_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        GOT_ESC,
        GOT_BRACKET
    } esc_state_e;

    esc_state_e       esc_state_q, esc_state_d;
    logic [ESC_W-1:0] esc_ticks_q, esc_ticks_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            esc_state_q <= IDLE;
            esc_ticks_q <= '0;
        end else begin
            esc_state_q <= esc_state_d;
            esc_ticks_q <= esc_ticks_d;
        end
    end

    always_comb begin
        esc_state_d = esc_state_q;
        esc_ticks_d = esc_ticks_q;
        decode_en   = 1'b1;
        arrow_mv    = '0;
        esc_unknown = 1'b0;
        case (esc_state_q)
            IDLE: begin
                if (rx_valid && rx_byte == 8'h1B) begin
                    esc_state_d = GOT_ESC;
                    esc_ticks_d = '0;
                    decode_en   = 1'b0;
                end
            end
            GOT_ESC: begin
                if (rx_valid) begin
                    esc_ticks_d = '0;
                    if (rx_byte == 8'h5B) begin
                        esc_state_d = GOT_BRACKET;
                        decode_en   = 1'b0;
                    end else begin
                        esc_state_d = IDLE;
                    end
                end
            end
            GOT_BRACKET: begin
                if (rx_valid) begin
                    esc_state_d = IDLE;
                    esc_ticks_d = '0;
                    decode_en   = 1'b0;
                    case (rx_byte)
                        8'h41:   arrow_mv    = 4'b0001;
                        8'h42:   arrow_mv    = 4'b0010;
                        8'h43:   arrow_mv    = 4'b1000;
                        8'h44:   arrow_mv    = 4'b0100;
                        default: esc_unknown = 1'b1;
                    endcase
                end
            end
            default: esc_state_d = IDLE;
        endcase
        // Abandon a half-received sequence after enough silent ticks
        if (esc_state_q != IDLE && !rx_valid && tick) begin
            if (esc_ticks_q >= ESC_W'(ESC_TIMEOUT_TICKS - 1)) begin
                esc_state_d = IDLE;
                esc_ticks_d = '0;
            end else begin
                esc_ticks_d = esc_ticks_q + ESC_W'(1);
            end
        end
    end
`else
    assign decode_en   = 1'b1;
    assign arrow_mv    = '0;
    assign esc_unknown = 1'b0;
`endif

    logic [3:0] key_mv;
    logic [2:0] key_act;
    logic       key_hit;
    logic       unknown_hit;

    always_comb begin
        key_mv      = '0;
        key_act     = '0;
        unknown_hit = 1'b0;
        if (rx_valid) begin
            if (decode_en) begin
                key_mv      = plain_mv;
                key_act     = plain_act;
                unknown_hit = (plain_mv == 4'b0000) && (plain_act == 3'b000);
            end else begin
                key_mv      = arrow_mv;
                unknown_hit = esc_unknown;
            end
        end
        key_hit = (key_mv != 4'b0000) || (key_act != 3'b000);
    end

    logic [3:0][3:0]            hold_q, hold_d;
    logic [FIFO_DEPTH-1:0][2:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [15:0]                instruction_q, instruction_d;
    logic                       any_key_q, any_key_d;
    logic                       overflow_q, overflow_d;
    logic [7:0]                 unknown_q, unknown_d;
    logic                       fifo_pop, fifo_full, fifo_push;

    always_comb begin
        hold_d        = hold_q;
        fifo_d        = fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        instruction_d = instruction_q;
        any_key_d     = key_hit;
        overflow_d    = overflow_q;
        unknown_d     = unknown_q;

        // Tick ages every live hold; a fresh key reloads it and cancels its opposite
        for (int i = 0; i < 4; i++) begin
            if (tick && hold_q[i] != 4'd0) begin
                hold_d[i] = hold_q[i] - 4'd1;
            end
        end
        if (key_mv[0]) begin
            hold_d[0] = HOLD_LOAD;
            hold_d[1] = '0;
        end
        if (key_mv[1]) begin
            hold_d[1] = HOLD_LOAD;
            hold_d[0] = '0;
        end
        if (key_mv[2]) begin
            hold_d[2] = HOLD_LOAD;
            hold_d[3] = '0;
        end
        if (key_mv[3]) begin
            hold_d[3] = HOLD_LOAD;
            hold_d[2] = '0;
        end

        // A pop in the same cycle frees the slot for a push into a full queue
        fifo_pop  = tick && (count_q != '0);
        fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
        fifo_push = (key_act != 3'b000) && (!fifo_full || fifo_pop);
        if (fifo_push) begin
            fifo_d[wr_ptr_q] = key_act;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: ;
        endcase
        if (key_act != 3'b000 && !fifo_push) begin
            overflow_d = 1'b1;
        end

        instruction_d[15:7] = '0;
        for (int i = 0; i < 4; i++) begin
            instruction_d[i] = (hold_q[i] != 4'd0);
        end
        if (tick) begin
            instruction_d[6:4] = fifo_pop ? fifo_q[rd_ptr_q] : 3'b000;
        end

        if (unknown_hit && unknown_q != 8'hFF) begin
            unknown_d = unknown_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q        <= '0;
            fifo_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            instruction_q <= '0;
            any_key_q     <= 1'b0;
            overflow_q    <= 1'b0;
            unknown_q     <= '0;
        end else begin
            hold_q        <= hold_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            instruction_q <= instruction_d;
            any_key_q     <= any_key_d;
            overflow_q    <= overflow_d;
            unknown_q     <= unknown_d;
        end
    end

    assign instruction   = instruction_q;
    assign any_key       = any_key_q;
    assign overflow      = overflow_q;
    assign unknown_count = unknown_q;

endmodule

// File: tb/tb_key_command_decoder.sv
// Directed self-checking bench for key_command_decoder (default parameters).
module tb_key_command_decoder;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        tick;
    logic [15:0] instruction;
    logic        any_key;
    logic        overflow;
    logic [7:0]  unknown_count;

    int total = 0;
    int bad   = 0;

    key_command_decoder dut (
        .clk           (clk),
        .reset         (reset),
        .rx_byte       (rx_byte),
        .rx_valid      (rx_valid),
        .tick          (tick),
        .instruction   (instruction),
        .any_key       (any_key),
        .overflow      (overflow),
        .unknown_count (unknown_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling clock edge.
    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic send_tick(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick     = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        tick     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        tick     = 1'b0;
        reset    = 1'b0;
        idle(2);
        chk("rst_instruction", instruction, 16'h0000);
        chk("rst_any_key", 16'(any_key), 16'h0000);
        chk("rst_overflow", 16'(overflow), 16'h0000);
        chk("rst_unknown", 16'(unknown_count), 16'h0000);
        reset = 1'b1;
        idle(1);

        // 'd': right appears two clocks after the byte, drops two clocks after the 3rd tick
        send("d");
        chk("d_any_key", 16'(any_key), 16'h0001);
        chk("d_lat1", instruction, 16'h0000);
        idle(1);
        chk("d_lat2", instruction, 16'h0008);
        chk("d_any_key_pulse", 16'(any_key), 16'h0000);
        pulse_tick();
        pulse_tick();
        idle(1);
        chk("d_after2ticks", instruction, 16'h0008);
        pulse_tick();
        chk("d_tick3_lat1", instruction, 16'h0008);
        idle(1);
        chk("d_released", instruction, 16'h0000);

        // Reload on the same cycle as a tick: the load wins
        send("w");
        idle(1);
        chk("w_up", instruction, 16'h0001);
        pulse_tick();
        pulse_tick();
        send_tick("w");
        pulse_tick();
        pulse_tick();
        idle(1);
        chk("w_load_beats_tick", instruction, 16'h0001);
        pulse_tick();
        idle(1);
        chk("w_released", instruction, 16'h0000);

        // Newest direction wins
        send("d");
        send("a");
        chk("da_mid", instruction, 16'h0008);
        idle(1);
        chk("da_left", instruction, 16'h0004);
        pulse_tick();
        pulse_tick();
        pulse_tick();
        idle(1);
        chk("da_released", instruction, 16'h0000);

        // Action queue ordering and one-tick pulses
        send(8'h20);
        send(8'h0D);
        send("x");
        chk("x_any_key", 16'(any_key), 16'h0001);
        idle(1);
        chk("q_before_tick", instruction, 16'h0000);
        pulse_tick();
        chk("q_action", instruction, 16'h0010);
        idle(2);
        chk("q_action_held", instruction, 16'h0010);
        pulse_tick();
        chk("q_confirm", instruction, 16'h0020);
        pulse_tick();
        chk("q_cancel", instruction, 16'h0040);
        pulse_tick();
        chk("q_empty", instruction, 16'h0000);
        send("Z");
        pulse_tick();
        chk("q_upper_z", instruction, 16'h0010);
        pulse_tick();
        chk("q_z_done", instruction, 16'h0000);
        chk("q_no_overflow", 16'(overflow), 16'h0000);

        // Five pushes into a depth-4 queue: one dropped
        repeat (4) send(8'h20);
        chk("ov_full_no_flag", 16'(overflow), 16'h0000);
        send(8'h20);
        chk("ov_set", 16'(overflow), 16'h0001);
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            chk("ov_pulse", instruction, 16'h0010);
        end
        pulse_tick();
        chk("ov_drained", instruction, 16'h0000);
        chk("ov_sticky", 16'(overflow), 16'h0001);

        // Push on a tick with the queue full is accepted
        do_reset();
        chk("ov_cleared", 16'(overflow), 16'h0000);
        repeat (4) send(8'h20);
        send_tick(8'h20);
        chk("pp_no_overflow", 16'(overflow), 16'h0000);
        chk("pp_pulse0", instruction, 16'h0010);
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            chk("pp_pulse", instruction, 16'h0010);
        end
        pulse_tick();
        chk("pp_drained", instruction, 16'h0000);

        do_reset();
`ifdef KEY_ARROW_EN
        send(8'h1B);
        send(8'h5B);
        send(8'h41);
        chk("esc_any_key", 16'(any_key), 16'h0001);
        idle(1);
        chk("esc_up", instruction, 16'h0001);
        chk("esc_unknown", 16'(unknown_count), 16'h0000);
        do_reset();
        send(8'h1B);
        pulse_tick();
        pulse_tick();
        send("w");
        idle(1);
        chk("esc_timeout_w", instruction, 16'h0001);
        chk("esc_timeout_unknown", 16'(unknown_count), 16'h0000);
        do_reset();
        send(8'h1B);
        pulse_tick();
        pulse_tick();
        send(8'h5B);
        send(8'h41);
        idle(1);
        chk("esc_timeout_plain", instruction, 16'h0004);
        chk("esc_timeout_bracket", 16'(unknown_count), 16'h0001);
        do_reset();
        send(8'h1B);
        send(8'h5B);
        send(8'h51);
        idle(1);
        chk("esc_bad_final", instruction, 16'h0000);
        chk("esc_bad_unknown", 16'(unknown_count), 16'h0001);
`else
        send(8'h41);
        chk("upper_a_any_key", 16'(any_key), 16'h0001);
        idle(1);
        chk("upper_a_left", instruction, 16'h0004);
        chk("upper_a_unknown", 16'(unknown_count), 16'h0000);
        send(8'h1B);
        send(8'h5B);
        chk("esc_plain_unknown", 16'(unknown_count), 16'h0002);
`endif

        // Unknown counter saturation
        do_reset();
        repeat (254) send(8'h7F);
        chk("unk_254", 16'(unknown_count), 16'h00FE);
        chk("unk_no_any_key", 16'(any_key), 16'h0000);
        repeat (46) send(8'h7F);
        chk("unk_sat", 16'(unknown_count), 16'h00FF);

        // Asynchronous reset in the middle of a hold and a queued action
        send(8'h20);
        send("s");
        idle(1);
        chk("mid_down", instruction, 16'h0002);
        reset = 1'b0;
        #1;
        chk("mid_rst_instruction", instruction, 16'h0000);
        chk("mid_rst_any_key", 16'(any_key), 16'h0000);
        chk("mid_rst_overflow", 16'(overflow), 16'h0000);
        chk("mid_rst_unknown", 16'(unknown_count), 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        chk("post_rst_hold", instruction, 16'h0000);
        pulse_tick();
        chk("post_rst_queue", instruction, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
